// File: rtl/sodor_fetch_pkg.sv
// Shared types for the Sodor instruction prefetch stage.
package sodor_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  // One buffered fetch result: the word address it came from and its data.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto an instruction-word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(INST_BYTES - 1));
  endfunction

endpackage

// File: rtl/sodor_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with wrap-around pointers,
// an occupancy count and a flush that beats push and pop.
module sodor_fetch_fifo
  import sodor_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop on an empty buffer is ignored; a push into a full buffer only
  // lands when a pop frees the slot in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_COUNT) || do_pop);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage array: written only, never reset (occupancy tracks validity).
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Upstream credit accounting must never push into a full buffer.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push && !do_pop) begin
      assert (count != FULL_COUNT);
    end
  end

endmodule

// File: rtl/sodor_imem_prefetch.sv
// Instruction prefetch stage: issues sequential word addresses to the
// memory model, captures the returned words a cycle later, buffers
// {pc, inst} pairs and hands them to the core. Redirects flush everything
// buffered or in flight and restart fetch at the new PC.
//
// Core handshake: fetch_valid says the head entry (fetch_pc/fetch_inst) is
// available; the entry transfers in any cycle where fetch_valid and
// fetch_ready are both high. While fetch_valid is high and fetch_ready is
// low the head entry is held stable (unless a redirect or reset flushes it).
module sodor_imem_prefetch
  import sodor_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_inst,
  input  logic        fetch_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [31:0] STEP         = 32'(INST_BYTES);

  logic [31:0]   npc;
  logic [31:0]   req_pc;
  logic          req_valid;
  logic [31:0]   rsp_pc;
  logic          rsp_valid;
  logic [31:0]   redirect_target;

  logic [CW-1:0] count;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  rsp_entry;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          pop;

  // Every word already buffered or still travelling through the request and
  // response registers holds one buffer slot, so a new address is only
  // presented when a slot is guaranteed to be free when its word arrives.
  assign credit_used     = {1'b0, count}
                         + {{CW{1'b0}}, req_valid}
                         + {{CW{1'b0}}, rsp_valid};
  assign issue           = !redirect_valid && (credit_used < CREDIT_LIMIT);
  assign redirect_target = align_pc(redirect_pc);

  assign pop       = fetch_valid && fetch_ready && !redirect_valid;
  assign rsp_entry = '{pc: rsp_pc, inst: imem_data};

  assign imem_addr   = req_pc;
  assign fetch_valid = !fifo_empty;
  assign fetch_pc    = fetch_valid ? head.pc   : '0;
  assign fetch_inst  = fetch_valid ? head.inst : '0;

  // Request/response pipeline and next-PC tracking. A redirect kills the
  // word in flight and presents the new target on the very next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      npc       <= RESET_PC;
      req_pc    <= RESET_PC;
      req_valid <= 1'b0;
      rsp_pc    <= '0;
      rsp_valid <= 1'b0;
    end else if (redirect_valid) begin
      npc       <= redirect_target + STEP;
      req_pc    <= redirect_target;
      req_valid <= 1'b1;
      rsp_pc    <= req_pc;
      rsp_valid <= 1'b0;
    end else begin
      rsp_pc    <= req_pc;
      rsp_valid <= req_valid;
      if (issue) begin
        req_pc    <= npc;
        req_valid <= 1'b1;
        npc       <= npc + STEP;
      end else begin
        req_valid <= 1'b0;
      end
    end
  end

  sodor_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (rsp_valid),
    .push_entry (rsp_entry),
    .pop        (pop),
    .head       (head),
    .empty      (fifo_empty),
    .count      (count)
  );

endmodule

// File: tb/tb_sodor_imem_prefetch.sv
// Bench for sodor_imem_prefetch: directed scenarios with literal expectations
// plus a randomized run, all checked by a stream-level model that knows only
// what PC must come next and when the head is allowed to be empty.
module tb_sodor_imem_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst;
  logic        fetch_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  sodor_imem_prefetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_inst     (fetch_inst),
    .fetch_ready    (fetch_ready)
  );

  // Memory model: word at address A is A ^ KEY, returned one cycle later.
  always @(posedge clk) imem_data <= imem_addr ^ KEY;

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stream model + compare process ----------------
  logic        model_on = 1'b0;
  logic        in_rst   = 1'b0;
  logic [31:0] exp_pc   = '0;
  int          blind    = 0;
  int          lowrun   = 0;
  logic        hold     = 1'b0;
  logic [31:0] hold_pc  = '0;
  logic [31:0] hold_inst = '0;

  always @(negedge clk) begin
    logic [31:0] d;
    if (model_on) begin
      if (in_rst) begin
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_addr",  imem_addr, RESET_PC);
        chk("rst_pc",    fetch_pc, 32'd0);
        chk("rst_inst",  fetch_inst, 32'd0);
      end
      if (blind > 0) chk("blind_valid", 32'(fetch_valid), 32'd0);
      if (fetch_valid) begin
        chk("head_pc",   fetch_pc, exp_pc);
        chk("head_inst", fetch_inst, exp_pc ^ KEY);
      end
      if (hold) begin
        chk("hold_valid", 32'(fetch_valid), 32'd1);
        chk("hold_pc",    fetch_pc, hold_pc);
        chk("hold_inst",  fetch_inst, hold_inst);
      end
      // Outstanding words never exceed DEPTH: the newest address is at most
      // DEPTH-1 words past the next PC to be consumed (or one word behind it).
      d = imem_addr - exp_pc + 32'd4;
      chk("credit_window", 32'(d <= 32'(4 * DEPTH)), 32'd1);
      chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (!fetch_valid && blind == 0 && !in_rst) lowrun++;
      else lowrun = 0;
      chk("liveness", 32'(lowrun > 3), 32'd0);
    end
    // advance the model across the coming clock edge
    if (reset) begin
      model_on = 1'b1;
      in_rst   = 1'b1;
      exp_pc   = RESET_PC;
      blind    = 3;
      hold     = 1'b0;
      lowrun   = 0;
    end else if (model_on) begin
      in_rst = 1'b0;
      hold   = fetch_valid && !fetch_ready && !redirect_valid;
      hold_pc   = fetch_pc;
      hold_inst = fetch_inst;
      if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        blind  = 2;
      end else begin
        if (fetch_valid && fetch_ready) exp_pc = exp_pc + 32'd4;
        if (blind > 0) blind--;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Expect blind_n empty cycles, then n heads pc0, pc0+4, ... one per cycle.
  task automatic run_heads(input int blind_n, input logic [31:0] pc0, input int n);
    logic [31:0] exp_q[$];
    for (int k = 0; k < n; k++) exp_q.push_back(pc0 + 32'(4 * k));
    for (int c = 0; c < blind_n + n; c++) begin
      @(negedge clk);
      if (c < blind_n) begin
        chk("dir_blind", 32'(fetch_valid), 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("dir_valid", 32'(fetch_valid), 32'd1);
        chk("dir_pc",    fetch_pc, e);
        chk("dir_inst",  fetch_inst, e ^ KEY);
      end
      cyc();
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] seen[$];
    logic [31:0] max_addr;
    logic        found;

    // Streaming from reset with the core always ready.
    fetch_ready = 1'b1;
    do_reset();
    run_heads(3, RESET_PC, 8);

    // Stall for 20 cycles: only four addresses may ever be requested.
    fetch_ready = 1'b0;
    do_reset();
    max_addr = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      found = 1'b0;
      foreach (seen[i]) if (seen[i] == imem_addr) found = 1'b1;
      if (!found) seen.push_back(imem_addr);
      if (imem_addr > max_addr) max_addr = imem_addr;
      cyc();
    end
    chk("stall_distinct", 32'(seen.size()), 32'd4);
    chk("stall_max_addr", max_addr, 32'h8000_000C);
    fetch_ready = 1'b1;
    run_heads(0, RESET_PC, 6);

    // Redirect with two words buffered and two in flight, core stalled.
    fetch_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    do_redirect(32'h0000_1002);
    run_heads(2, 32'h0000_1000, 1);
    fetch_ready = 1'b1;
    run_heads(0, 32'h0000_1000, 4);

    // Redirect near the top of the address space: fetch wraps to zero.
    do_redirect(32'hFFFF_FFF8);
    run_heads(2, 32'hFFFF_FFF8, 4);

    // Back-to-back redirects: only the second target is ever emitted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cyc();
    do_redirect(32'h0000_0200);
    run_heads(2, 32'h0000_0200, 3);

    // Reset in the middle of a stalled stream.
    fetch_ready = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    fetch_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(fetch_valid), 32'd0);
    chk("midrst_addr",  imem_addr, RESET_PC);
    cyc();
    run_heads(2, RESET_PC, 4);

    // Randomized traffic: ready stalls, redirects (incl. near wrap), resets.
    for (int c = 0; c < 3000; c++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: redirect_pc = 32'($urandom_range(0, 255));
      endcase
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset          = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    cyc();

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
